// File: rtl/psum_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : psum_accumulator
// Purpose  : Accumulates Tout-lane partial-sum vectors from the PE engine
//            across input-channel tiles in an internal psum RAM using a
//            read-modify-write pipeline. On the last input-channel tile the
//            finished vector and its psum address are pushed into a small
//            output FIFO for the writeback stage.
// Ports    : clk, rstn (async, active-low)
//            i_vld, i_acc_flat, i_row, i_col, i_chn_out,
//            i_first_tin, i_last_tin       - PE result vector and its tags
//            q_width, q_cout_tiles         - static layer configuration
//            o_out_vld, o_out_data, o_out_addr, i_out_rdy - output FIFO head
//            o_almost_full                 - FIFO count >= OF_DEPTH-3
//            o_err_ovf                     - sticky FIFO overflow flag
// Revision : 1.0 - initial release
// ============================================================================
module psum_accumulator #(
    parameter int W_SIZE    = 8,
    parameter int W_CHANNEL = 4,
    parameter int Tout      = 4,
    parameter int W_PSUM    = 32,
    parameter int BUF_AW    = 8,
    parameter int OF_DEPTH  = 4    // power of 2, >= 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_vld,
    input  logic [Tout*W_PSUM-1:0]   i_acc_flat,
    input  logic [W_SIZE-1:0]        i_row,
    input  logic [W_SIZE-1:0]        i_col,
    input  logic [W_CHANNEL-1:0]     i_chn_out,
    input  logic                     i_first_tin,
    input  logic                     i_last_tin,
    input  logic [W_SIZE-1:0]        q_width,
    input  logic [W_CHANNEL-1:0]     q_cout_tiles,
    output logic                     o_out_vld,
    output logic [Tout*W_PSUM-1:0]   o_out_data,
    output logic [BUF_AW-1:0]        o_out_addr,
    input  logic                     i_out_rdy,
    output logic                     o_almost_full,
    output logic                     o_err_ovf
);

    localparam int c_dw = Tout * W_PSUM;
    localparam int c_pw = $clog2(OF_DEPTH);
    localparam int c_cw = c_pw + 1;
    localparam logic [c_cw-1:0] c_full_level = c_cw'(OF_DEPTH);
    localparam logic [c_cw-1:0] c_af_level   = c_cw'(OF_DEPTH - 3);

    // ------------------------------------------------------------------
    // Address generation. All operands are cast to BUF_AW bits up front:
    // truncation mod 2**BUF_AW commutes with + and *, so this equals the
    // full-width result truncated.
    // ------------------------------------------------------------------
    logic [BUF_AW-1:0] w_addr;
    assign w_addr = (BUF_AW'(i_row) * BUF_AW'(q_width) + BUF_AW'(i_col))
                    * BUF_AW'(q_cout_tiles) + BUF_AW'(i_chn_out);

    // Pipeline registers: s1 = RAM read issue, s2 = add + write-back.
    logic              r_s1_vld, r_s1_first, r_s1_last;
    logic [BUF_AW-1:0] r_s1_addr;
    logic [c_dw-1:0]   r_s1_acc;
    logic              r_s2_vld, r_s2_first, r_s2_last;
    logic [BUF_AW-1:0] r_s2_addr;
    logic [c_dw-1:0]   r_s2_acc;
    logic              r_fwd_vld;
    logic [c_dw-1:0]   r_fwd_data;
    logic [c_dw-1:0]   r_rd_data;
    logic [c_dw-1:0]   r_psum_mem [2**BUF_AW];

    logic [c_dw-1:0]   w_old;
    logic [c_dw-1:0]   w_sum;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_vld   <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_acc   <= '0;
            r_s2_vld   <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_acc   <= '0;
            r_fwd_vld  <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_s1_vld <= i_vld;
            if (i_vld) begin
                r_s1_first <= i_first_tin;
                r_s1_last  <= i_last_tin;
                r_s1_addr  <= w_addr;
                r_s1_acc   <= i_acc_flat;
            end
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_first <= r_s1_first;
                r_s2_last  <= r_s1_last;
                r_s2_addr  <= r_s1_addr;
                r_s2_acc   <= r_s1_acc;
            end
            // The RAM read issued this edge returns the pre-write value when
            // s2 writes the same address on the same edge. Capture the value
            // being written so s2 can use it next cycle. This is the only
            // hazard window: a write one cycle earlier hitting the address now
            // in s2 is exactly this same edge seen from the following cycle.
            r_fwd_vld  <= r_s1_vld && r_s2_vld && (r_s1_addr == r_s2_addr);
            r_fwd_data <= w_sum;
        end
    end

    // psum RAM: synchronous read, read-before-write on a collision.
    always_ff @(posedge clk) begin
        if (r_s2_vld)
            r_psum_mem[r_s2_addr] <= w_sum;
        if (r_s1_vld && !r_s1_first)
            r_rd_data <= r_psum_mem[r_s1_addr];
    end

    assign w_old = r_fwd_vld ? r_fwd_data : r_rd_data;

    // Lane-wise add, wrapping mod 2**W_PSUM.
    always_comb begin
        w_sum = '0;
        for (int g = 0; g < Tout; g++) begin
            w_sum[g*W_PSUM +: W_PSUM] = r_s2_first
                ? r_s2_acc[g*W_PSUM +: W_PSUM]
                : w_old[g*W_PSUM +: W_PSUM] + r_s2_acc[g*W_PSUM +: W_PSUM];
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [c_dw-1:0]   r_fifo_data [OF_DEPTH];
    logic [BUF_AW-1:0] r_fifo_addr [OF_DEPTH];
    logic [c_pw-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_cw-1:0]   r_count;
    logic              r_err_ovf;
    logic              w_push, w_pop, w_full, w_push_ok;

    assign w_full    = (r_count == c_full_level);
    assign w_push    = r_s2_vld & r_s2_last;
    assign w_pop     = (r_count != '0) & i_out_rdy;
    // A push into a full FIFO is accepted only if the head leaves the same
    // cycle; the write then lands in the slot being vacated.
    assign w_push_ok = w_push & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < OF_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_addr[i] <= '0;
            end
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_err_ovf <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_fifo_data[r_wr_ptr] <= w_sum;
                r_fifo_addr[r_wr_ptr] <= r_s2_addr;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_push_ok)
                r_err_ovf <= 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_out_vld     = (r_count != '0);
    assign o_out_data    = r_fifo_data[r_rd_ptr];
    assign o_out_addr    = r_fifo_addr[r_rd_ptr];
    assign o_almost_full = (r_count >= c_af_level);
    assign o_err_ovf     = r_err_ovf;

endmodule
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_psum_accumulator
// Purpose  : Self-checking bench for psum_accumulator. A table of vectors with
//            expected results plus hand-written multi-cycle sequences; expected
//            outputs are queued when stimulus is driven and compared when the
//            DUT hands over its FIFO head.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psum_accumulator;

    localparam int W_SIZE    = 8;
    localparam int W_CHANNEL = 4;
    localparam int Tout      = 4;
    localparam int W_PSUM    = 32;
    localparam int BUF_AW    = 8;
    localparam int OF_DEPTH  = 4;
    localparam int DW        = Tout * W_PSUM;

    logic                 clk;
    logic                 rstn;
    logic                 i_vld;
    logic [DW-1:0]        i_acc_flat;
    logic [W_SIZE-1:0]    i_row, i_col;
    logic [W_CHANNEL-1:0] i_chn_out;
    logic                 i_first_tin, i_last_tin;
    logic [W_SIZE-1:0]    q_width;
    logic [W_CHANNEL-1:0] q_cout_tiles;
    logic                 o_out_vld;
    logic [DW-1:0]        o_out_data;
    logic [BUF_AW-1:0]    o_out_addr;
    logic                 i_out_rdy;
    logic                 o_almost_full;
    logic                 o_err_ovf;

    psum_accumulator #(
        .W_SIZE(W_SIZE), .W_CHANNEL(W_CHANNEL), .Tout(Tout),
        .W_PSUM(W_PSUM), .BUF_AW(BUF_AW), .OF_DEPTH(OF_DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn),
        .i_vld(i_vld), .i_acc_flat(i_acc_flat),
        .i_row(i_row), .i_col(i_col), .i_chn_out(i_chn_out),
        .i_first_tin(i_first_tin), .i_last_tin(i_last_tin),
        .q_width(q_width), .q_cout_tiles(q_cout_tiles),
        .o_out_vld(o_out_vld), .o_out_data(o_out_data), .o_out_addr(o_out_addr),
        .i_out_rdy(i_out_rdy), .o_almost_full(o_almost_full), .o_err_ovf(o_err_ovf)
    );

    typedef struct packed {
        logic [7:0]    row;
        logic [7:0]    col;
        logic [3:0]    chn;
        logic          first;
        logic          last;
        logic [DW-1:0] acc;
        logic [7:0]    eaddr;
        logic [DW-1:0] eout;
    } vec_t;

    typedef struct packed {
        logic [7:0]    addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [DW-1:0] L(input logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic vec_t mk(input int row, col, chn, input logic first, last,
                                input logic [DW-1:0] acc, input int eaddr,
                                input logic [DW-1:0] eout);
        vec_t v;
        v.row = 8'(row); v.col = 8'(col); v.chn = 4'(chn);
        v.first = first; v.last = last; v.acc = acc;
        v.eaddr = 8'(eaddr); v.eout = eout;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_vld = 1'b0; i_first_tin = 1'b0; i_last_tin = 1'b0;
    endtask

    task automatic drive(input vec_t v, input logic push_exp);
        exp_t e;
        i_vld = 1'b1; i_row = v.row; i_col = v.col; i_chn_out = v.chn;
        i_first_tin = v.first; i_last_tin = v.last; i_acc_flat = v.acc;
        if (v.last && push_exp) begin
            e.addr = v.eaddr; e.data = v.eout;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((sb_q.size() != 0 || o_out_vld) && k < 50) begin
            tick();
            k++;
        end
        check({name, "_queue_empty"}, DW'(sb_q.size()), '0);
        check({name, "_vld_low"}, DW'(o_out_vld), '0);
    endtask

    // Compares the FIFO head against the scoreboard on every handshake.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn && o_out_vld && i_out_rdy) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_emit: got addr %0d data %h, expected no output",
                             o_out_addr, o_out_data);
                end else begin
                    e = sb_q.pop_front();
                    check("emit_data", o_out_data, e.data);
                    check("emit_addr", DW'(o_out_addr), DW'(e.addr));
                end
            end
        end
    endtask

    vec_t tbl [12];
    vec_t v;
    vec_t v0;
    int   lat;

    initial begin
        tbl[0]  = mk(0, 0, 0, 1, 1, L(1, 2, 3, 4), 0, L(1, 2, 3, 4));
        tbl[1]  = mk(1, 3, 1, 1, 1, L(5, 6, 7, 8), 15, L(5, 6, 7, 8));
        tbl[2]  = mk(0, 1, 0, 1, 0, L(10, 10, 10, 10), 2, '0);
        tbl[3]  = mk(0, 1, 0, 0, 0, L(20, 20, 20, 20), 2, '0);
        tbl[4]  = mk(0, 1, 0, 0, 1, L(30, 30, 30, 30), 2, L(60, 60, 60, 60));
        tbl[5]  = mk(0, 1, 1, 1, 0, L(32'h7FFFFFFF, 32'hFFFFFFFB, 0, 32'hFFFFFFFF), 3, '0);
        tbl[6]  = mk(0, 1, 1, 0, 1, L(1, 3, 0, 1), 3, L(32'h80000000, 32'hFFFFFFFE, 0, 0));
        tbl[7]  = mk(0, 2, 0, 1, 0, L(100, 200, 300, 400), 4, '0);
        tbl[8]  = mk(0, 2, 1, 1, 0, L(1, 1, 1, 1), 5, '0);
        tbl[9]  = mk(0, 2, 0, 0, 1, L(1, 2, 3, 4), 4, L(101, 202, 303, 404));
        tbl[10] = mk(0, 2, 1, 0, 1, L(2, 2, 2, 2), 5, L(3, 3, 3, 3));
        tbl[11] = mk(40, 0, 0, 1, 1, L(9, 8, 7, 6), 64, L(9, 8, 7, 6));

        rstn = 1'b0; i_out_rdy = 1'b1;
        i_row = '0; i_col = '0; i_chn_out = '0; i_acc_flat = '0;
        q_width = 8'd4; q_cout_tiles = 4'd2;
        idle();
        fork monitor(); join_none

        // Reset state
        repeat (3) tick();
        check("rst_out_vld", DW'(o_out_vld), '0);
        check("rst_out_data", o_out_data, '0);
        check("rst_out_addr", DW'(o_out_addr), '0);
        check("rst_almost_full", DW'(o_almost_full), '0);
        check("rst_err_ovf", DW'(o_err_ovf), '0);
        rstn = 1'b1;
        repeat (2) tick();

        // Single tile, latency from the input cycle to o_out_vld
        drive(mk(0, 0, 0, 1, 1, L(1, 2, 3, 4), 0, L(1, 2, 3, 4)), 1'b1);
        tick();
        idle();
        lat = 1;
        while (!o_out_vld && lat < 10) begin
            tick();
            lat++;
        end
        check("latency", DW'(lat), DW'(3));
        check("af_at_count1", DW'(o_almost_full), DW'(1));
        drain("single");

        // Table vectors, back to back
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i], 1'b1);
            tick();
        end
        idle();
        drain("table");

        // Three tiles on one pixel, five cycles apart
        drive(mk(1, 0, 0, 1, 0, L(7, 7, 7, 7), 8, '0), 1'b1);
        tick(); idle(); repeat (4) tick();
        drive(mk(1, 0, 0, 0, 0, L(7, 7, 7, 7), 8, '0), 1'b1);
        tick(); idle(); repeat (4) tick();
        check("no_early_emit", DW'(o_out_vld), '0);
        drive(mk(1, 0, 0, 0, 1, L(7, 7, 7, 7), 8, L(21, 21, 21, 21)), 1'b1);
        tick(); idle();
        drain("three_tiles");

        // Consumer stalled: five emits into a four-deep FIFO
        i_out_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            v = mk(2, k / 2, k % 2, 1, 1,
                   L(k * 16 + 1, k * 16 + 2, k * 16 + 3, k * 16 + 4), 16 + k,
                   L(k * 16 + 1, k * 16 + 2, k * 16 + 3, k * 16 + 4));
            if (k == 0) v0 = v;
            drive(v, k < 4);
            tick();
            if (k == 1) check("af_empty", DW'(o_almost_full), '0);
            if (k == 2) begin
                check("af_first_push", DW'(o_almost_full), DW'(1));
                check("vld_first_push", DW'(o_out_vld), DW'(1));
            end
        end
        idle();
        tick();
        check("ovf_not_yet", DW'(o_err_ovf), '0);
        tick();
        tick();
        check("ovf_sticky", DW'(o_err_ovf), DW'(1));
        check("held_vld", DW'(o_out_vld), DW'(1));
        check("held_data", o_out_data, v0.eout);
        check("held_addr", DW'(o_out_addr), DW'(16));
        i_out_rdy = 1'b1;
        drain("overflow");
        check("ovf_still_set", DW'(o_err_ovf), DW'(1));

        // Reset with one entry in the FIFO and one vector in flight
        i_out_rdy = 1'b0;
        drive(mk(3, 0, 0, 1, 1, L(1, 1, 1, 1), 24, L(1, 1, 1, 1)), 1'b0);
        tick();
        drive(mk(3, 0, 1, 1, 1, L(2, 2, 2, 2), 25, L(2, 2, 2, 2)), 1'b0);
        tick();
        idle();
        tick();
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_out_vld", DW'(o_out_vld), '0);
        check("midrst_out_data", o_out_data, '0);
        check("midrst_out_addr", DW'(o_out_addr), '0);
        check("midrst_almost_full", DW'(o_almost_full), '0);
        check("midrst_err_ovf", DW'(o_err_ovf), '0);
        tick();
        rstn = 1'b1;
        i_out_rdy = 1'b1;
        repeat (6) tick();
        check("no_stale_emit", DW'(o_out_vld), '0);
        check("no_stale_queue", DW'(sb_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
